// File: rtl/conv_feeder_pkg.sv
// conv_feeder_pkg: shared types and constants for the conv operand feeder.
//   state_t        - job FSM states
//   IFM_W, WGT_W   - operand word widths
//   ADDR_W, LEN_W  - SRAM address width and word-count width
//   PREFETCH_DEPTH - entries in each stream's prefetch FIFO
package conv_feeder_pkg;

  localparam int IFM_W          = 48;
  localparam int WGT_W          = 24;
  localparam int ADDR_W         = 12;
  localparam int LEN_W          = ADDR_W + 1;
  localparam int PREFETCH_DEPTH = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRIME    = 3'd1,
    RUN      = 3'd2,
    WAIT_END = 3'd3,
    FIN      = 3'd4
  } state_t;

endpackage

// File: rtl/conv_feeder_stream.sv
// feed_stream: one operand stream. Fetches len words from a 1-cycle-latency
// SRAM starting at base into a 2-entry prefetch FIFO and pops one word per
// read strobe.
//   load           - latch base/len and clear counters/FIFO (job start)
//   active         - fetching permitted
//   mem_en/addr    - SRAM read request; mem_rdata valid the following cycle
//   read           - consumer strobe; pops the head when the FIFO is non-empty
//   head           - FIFO head word, 0 when empty
//   head_valid_nxt - FIFO will be non-empty in the next cycle
//   all_popped     - len words have been popped
//   underrun       - read strobe seen this cycle with an empty FIFO
//
// Handshake: the head is offered whenever the FIFO is non-empty; a read
// strobe in a cycle with a non-empty FIFO consumes exactly that head word.
// A strobe against an empty FIFO consumes nothing and is flagged as underrun.
module feed_stream
  import conv_feeder_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              active,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              read,
  output logic [DW-1:0]     head,
  output logic              head_valid_nxt,
  output logic              all_popped,
  output logic              underrun
);

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  popped;
  logic              in_flight;
  logic [1:0]        count;
  logic [DW-1:0]     fifo_q [PREFETCH_DEPTH];
  logic              rd_ptr;
  logic              wr_ptr;

  logic              head_valid;
  logic              pop;
  logic [2:0]        occ;
  logic [1:0]        count_nxt;

  assign head_valid = (count != 2'd0);
  assign pop        = read && head_valid;
  assign underrun   = read && !head_valid;

  // Occupancy already credits a pop happening this cycle, so a steady reader
  // keeps one word landing every cycle instead of stalling every other one.
  assign occ       = {1'b0, count} + {2'b0, in_flight} - {2'b0, pop};
  assign count_nxt = count + {1'b0, in_flight} - {1'b0, pop};

  assign mem_en   = active && (issued < len_q) && (occ < 3'(PREFETCH_DEPTH));
  assign mem_addr = mem_en ? (base_q + issued[ADDR_W-1:0]) : '0;

  assign head           = head_valid ? fifo_q[rd_ptr] : '0;
  assign head_valid_nxt = (count_nxt != 2'd0);
  assign all_popped     = (popped == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      len_q     <= '0;
      issued    <= '0;
      popped    <= '0;
      in_flight <= 1'b0;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      for (int i = 0; i < PREFETCH_DEPTH; i++) fifo_q[i] <= '0;
    end else if (load) begin
      base_q    <= base;
      len_q     <= len;
      issued    <= '0;
      popped    <= '0;
      in_flight <= 1'b0;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
    end else begin
      in_flight <= mem_en;
      count     <= count_nxt;
      if (mem_en) issued <= issued + 1'b1;
      // Data requested last cycle arrives now.
      if (in_flight) begin
        fifo_q[wr_ptr] <= mem_rdata;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        popped <= popped + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_feeder.sv
// conv_feeder: feeds the conv accelerator its ifm (48-bit) and weight
// (24-bit) operand streams from two single-port SRAMs, issues start_conv
// once both streams are primed and reports job completion.
//   start, *_base, *_len     - job request (ignored while busy)
//   ifm_mem_*, wgt_mem_*     - SRAM read ports (1-cycle read latency)
//   ifm/ifm_read, weight/wgt_read - operand heads and consume strobes
//   start_conv / end_conv    - accelerator start pulse / completion pulse
//   busy, done, err_underrun - job status; err_underrun is sticky to next start
//   dbg_state                - current FSM state
module conv_feeder
  import conv_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [LEN_W-1:0]  ifm_len,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [LEN_W-1:0]  wgt_len,
  output logic              ifm_mem_en,
  output logic [ADDR_W-1:0] ifm_mem_addr,
  input  logic [IFM_W-1:0]  ifm_mem_rdata,
  output logic              wgt_mem_en,
  output logic [ADDR_W-1:0] wgt_mem_addr,
  input  logic [WGT_W-1:0]  wgt_mem_rdata,
  output logic [IFM_W-1:0]  ifm,
  input  logic              ifm_read,
  output logic [WGT_W-1:0]  weight,
  input  logic              wgt_read,
  output logic              start_conv,
  input  logic              end_conv,
  output logic              busy,
  output logic              done,
  output logic              err_underrun,
  output logic [2:0]        dbg_state
);

  state_t state;
  logic   end_seen;
  logic   load;
  logic   active;
  logic   ifm_nv, wgt_nv;
  logic   ifm_all, wgt_all;
  logic   ifm_under, wgt_under;

  assign load      = (state == IDLE) && start;
  assign active    = (state == PRIME) || (state == RUN) || (state == WAIT_END);
  assign dbg_state = state;

  feed_stream #(.DW(IFM_W)) u_ifm (
    .clk(clk), .rst_n(rst_n), .load(load), .active(active),
    .base(ifm_base), .len(ifm_len),
    .mem_en(ifm_mem_en), .mem_addr(ifm_mem_addr), .mem_rdata(ifm_mem_rdata),
    .read(ifm_read), .head(ifm), .head_valid_nxt(ifm_nv),
    .all_popped(ifm_all), .underrun(ifm_under)
  );

  feed_stream #(.DW(WGT_W)) u_wgt (
    .clk(clk), .rst_n(rst_n), .load(load), .active(active),
    .base(wgt_base), .len(wgt_len),
    .mem_en(wgt_mem_en), .mem_addr(wgt_mem_addr), .mem_rdata(wgt_mem_rdata),
    .read(wgt_read), .head(weight), .head_valid_nxt(wgt_nv),
    .all_popped(wgt_all), .underrun(wgt_under)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      end_seen     <= 1'b0;
      start_conv   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      start_conv <= 1'b0;
      done       <= 1'b0;
      if (ifm_under || wgt_under) err_underrun <= 1'b1;
      case (state)
        IDLE: begin
          // end_conv while idle belongs to no job and is dropped.
          end_seen <= 1'b0;
          if (start) begin
            err_underrun <= 1'b0;
            if ((ifm_len == '0) || (wgt_len == '0)) begin
              state <= FIN;
            end else begin
              state <= PRIME;
              busy  <= 1'b1;
            end
          end
        end
        PRIME: begin
          if (end_conv) end_seen <= 1'b1;
          // Registered start_conv lines up with the first cycle both heads
          // are visible to the accelerator.
          if (ifm_nv && wgt_nv) begin
            start_conv <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (end_conv) end_seen <= 1'b1;
          if (ifm_all && wgt_all) state <= WAIT_END;
        end
        WAIT_END: begin
          if (end_conv || end_seen) begin
            state <= FIN;
            busy  <= 1'b0;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_feeder.sv
module tb_conv_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] ifm_base, wgt_base;
  logic [12:0] ifm_len, wgt_len;
  logic        ifm_mem_en, wgt_mem_en;
  logic [11:0] ifm_mem_addr, wgt_mem_addr;
  logic [47:0] ifm_mem_rdata;
  logic [23:0] wgt_mem_rdata;
  logic [47:0] ifm;
  logic [23:0] weight;
  logic        ifm_read, wgt_read;
  logic        start_conv, end_conv;
  logic        busy, done, err_underrun;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ifm_base(ifm_base), .ifm_len(ifm_len),
    .wgt_base(wgt_base), .wgt_len(wgt_len),
    .ifm_mem_en(ifm_mem_en), .ifm_mem_addr(ifm_mem_addr), .ifm_mem_rdata(ifm_mem_rdata),
    .wgt_mem_en(wgt_mem_en), .wgt_mem_addr(wgt_mem_addr), .wgt_mem_rdata(wgt_mem_rdata),
    .ifm(ifm), .ifm_read(ifm_read), .weight(weight), .wgt_read(wgt_read),
    .start_conv(start_conv), .end_conv(end_conv),
    .busy(busy), .done(done), .err_underrun(err_underrun), .dbg_state(dbg_state)
  );

  function automatic logic [47:0] ifm_pat(input logic [11:0] a);
    return {24'hC0FFEE, 12'h000, a};
  endfunction

  function automatic logic [23:0] wgt_pat(input logic [11:0] a);
    return {12'hB0B, a};
  endfunction

  // SRAM models: 1-cycle read latency.
  always @(posedge clk) begin
    if (ifm_mem_en) ifm_mem_rdata <= ifm_pat(ifm_mem_addr);
    if (wgt_mem_en) wgt_mem_rdata <= wgt_pat(wgt_mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic launch(input logic [11:0] ib, input logic [12:0] il,
                        input logic [11:0] wb, input logic [12:0] wl);
    ifm_base = ib; ifm_len = il; wgt_base = wb; wgt_len = wl;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_end();
    end_conv = 1'b1;
    step();
    end_conv = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 12) begin
      step();
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
    step();
    check({tag, "_done_once"}, done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    int en_cnt;
    int done_cnt;
    rst_n = 1'b0; start = 1'b0; end_conv = 1'b0;
    ifm_read = 1'b0; wgt_read = 1'b0;
    ifm_base = '0; ifm_len = '0; wgt_base = '0; wgt_len = '0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_ifm_en", ifm_mem_en, 0);
    check("rst_start_conv", start_conv, 0);
    check("rst_err", err_underrun, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    step();

    // Basic job.
    launch(12'h010, 13'd4, 12'h100, 13'd3);
    check("t1_busy", busy, 1);
    check("t1_en_c1", ifm_mem_en, 1);
    check("t1_addr_c1", ifm_mem_addr, 12'h010);
    check("t1_sc_c1", start_conv, 0);
    step();
    check("t1_sc_c2", start_conv, 0);
    step();
    check("t1_sc_c3", start_conv, 1);
    for (int k = 0; k < 4; k++) begin
      ifm_read = 1'b1;
      wgt_read = (k < 3);
      check($sformatf("t1_ifm%0d", k), ifm, ifm_pat(12'h010 + 12'(k)));
      if (k < 3) check($sformatf("t1_wgt%0d", k), weight, wgt_pat(12'h100 + 12'(k)));
      if (k == 1) check("t1_sc_pulse", start_conv, 0);
      step();
    end
    ifm_read = 1'b0; wgt_read = 1'b0;
    check("t1_ifm_empty", ifm, 0);
    repeat (2) step();
    check("t1_busy_wait", busy, 1);
    pulse_end();
    wait_done("t1");
    check("t1_err", err_underrun, 0);

    // Back-pressure: no reads for 10 cycles after start_conv.
    launch(12'h200, 13'd8, 12'h300, 13'd8);
    en_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (ifm_mem_en) en_cnt++;
      if (c == 3) check("t2_sc_c3", start_conv, 1);
      step();
    end
    check("t2_fetch_cnt", en_cnt, 2);
    check("t2_en_idle", ifm_mem_en, 0);
    for (int k = 0; k < 8; k++) begin
      ifm_read = 1'b1; wgt_read = 1'b1;
      end_conv = (k == 2);
      check($sformatf("t2_ifm%0d", k), ifm, ifm_pat(12'h200 + 12'(k)));
      check($sformatf("t2_wgt%0d", k), weight, wgt_pat(12'h300 + 12'(k)));
      step();
    end
    ifm_read = 1'b0; wgt_read = 1'b0; end_conv = 1'b0;
    check("t2_ifm_empty", ifm, 0);
    wait_done("t2");
    check("t2_err", err_underrun, 0);

    // Underrun: second weight strobe against an exhausted stream.
    launch(12'h400, 13'd1, 12'h500, 13'd1);
    repeat (2) step();
    check("t3_sc", start_conv, 1);
    ifm_read = 1'b1; wgt_read = 1'b1;
    check("t3_ifm0", ifm, ifm_pat(12'h400));
    check("t3_wgt0", weight, wgt_pat(12'h500));
    step();
    ifm_read = 1'b0; wgt_read = 1'b1;
    check("t3_wgt_zero", weight, 0);
    check("t3_err_before", err_underrun, 0);
    step();
    wgt_read = 1'b0;
    check("t3_err_set", err_underrun, 1);
    pulse_end();
    wait_done("t3");
    check("t3_err_sticky", err_underrun, 1);

    // Zero-length job.
    launch(12'h600, 13'd0, 12'h610, 13'd5);
    check("t4_err_cleared", err_underrun, 0);
    check("t4_done_c1", done, 0);
    check("t4_busy", busy, 0);
    en_cnt = ifm_mem_en + wgt_mem_en + start_conv;
    step();
    check("t4_done_c2", done, 1);
    en_cnt += ifm_mem_en + wgt_mem_en + start_conv;
    step();
    check("t4_done_c3", done, 0);
    en_cnt += ifm_mem_en + wgt_mem_en + start_conv;
    check("t4_no_activity", en_cnt, 0);
    // Strobe while idle is an underrun.
    ifm_read = 1'b1;
    step();
    ifm_read = 1'b0;
    check("t4_idle_underrun", err_underrun, 1);

    // Reset mid-RUN after 2 of 5 words popped.
    launch(12'h020, 13'd5, 12'h040, 13'd5);
    check("t5_err_cleared", err_underrun, 0);
    repeat (2) step();
    check("t5_sc", start_conv, 1);
    for (int k = 0; k < 2; k++) begin
      ifm_read = 1'b1; wgt_read = 1'b1;
      check($sformatf("t5_ifm%0d", k), ifm, ifm_pat(12'h020 + 12'(k)));
      step();
    end
    ifm_read = 1'b0; wgt_read = 1'b0;
    check("t5_head_pre_rst", ifm, ifm_pat(12'h022));
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ifm", ifm, 0);
    check("t5_rst_weight", weight, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_en", {ifm_mem_en, wgt_mem_en}, 0);
    check("t5_rst_addr", {ifm_mem_addr, wgt_mem_addr}, 0);
    check("t5_rst_misc", {start_conv, done, err_underrun}, 0);
    check("t5_rst_state", dbg_state, 0);
    step();
    rst_n = 1'b1;
    step();

    // Fresh job replays from base; end_conv alongside start is dropped;
    // start during RUN is ignored.
    end_conv = 1'b1;
    launch(12'h020, 13'd5, 12'h040, 13'd5);
    end_conv = 1'b0;
    check("t6_addr_c1", ifm_mem_addr, 12'h020);
    repeat (2) step();
    check("t6_sc", start_conv, 1);
    for (int k = 0; k < 5; k++) begin
      ifm_read = 1'b1; wgt_read = 1'b1;
      start = (k == 1);
      if (k == 1) begin
        ifm_base = 12'h7F0; wgt_base = 12'h7A0;
      end
      check($sformatf("t6_ifm%0d", k), ifm, ifm_pat(12'h020 + 12'(k)));
      check($sformatf("t6_wgt%0d", k), weight, wgt_pat(12'h040 + 12'(k)));
      step();
    end
    ifm_read = 1'b0; wgt_read = 1'b0; start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) done_cnt++;
      step();
    end
    check("t6_no_early_done", done_cnt, 0);
    check("t6_busy_hold", busy, 1);
    pulse_end();
    wait_done("t6");

    // Address wrap modulo 2^12.
    launch(12'hFFE, 13'd3, 12'hFFF, 13'd2);
    repeat (2) step();
    check("t7_sc", start_conv, 1);
    for (int k = 0; k < 3; k++) begin
      ifm_read = 1'b1; wgt_read = (k < 2);
      a = 12'hFFE + 12'(k);
      check($sformatf("t7_ifm%0d", k), ifm, ifm_pat(a));
      a = 12'hFFF + 12'(k);
      if (k < 2) check($sformatf("t7_wgt%0d", k), weight, wgt_pat(a));
      step();
    end
    ifm_read = 1'b0; wgt_read = 1'b0;
    pulse_end();
    wait_done("t7");
    check("t7_err", err_underrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
